// File: rtl/umips_storemerge_if.sv
// Store request / data memory bus bundle for umips_storemerge.
// mem_be exists only when UMIPS_STORE_BE_EN is defined.
interface umips_storemerge_if #(
  parameter int unsigned ADDR_W = 30
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_byte_n;
  logic              req_byte_sel;
  logic              req_word_sel;
  logic [31:0]       req_wdata;
  logic              done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
`ifdef UMIPS_STORE_BE_EN
  logic [3:0]        mem_be;
`endif
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_addr, req_byte_n, req_byte_sel, req_word_sel, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, done, mem_req, mem_we, mem_addr, mem_wdata
`ifdef UMIPS_STORE_BE_EN
    , output mem_be
`endif
  );

  modport master (
    output req_valid, req_addr, req_byte_n, req_byte_sel, req_word_sel, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, done, mem_req, mem_we, mem_addr, mem_wdata
`ifdef UMIPS_STORE_BE_EN
    , input mem_be
`endif
  );
endinterface

// File: rtl/umips_storemerge.sv
// Store lane placer and single-port memory write sequencer (RMW for sub-words).
// Define UMIPS_STORE_BE_EN to write sub-words directly with byte enables.
module umips_storemerge #(
  parameter int unsigned ADDR_W = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  umips_storemerge_if.slave  bus
);

`ifdef UMIPS_STORE_BE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic [3:0]        w_req_mask;
  logic [31:0]       w_req_fill;
  logic [3:0]        r_mask;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_done;
`ifdef UMIPS_STORE_BE_EN
  logic [3:0]        r_mem_be;
`endif

  // Lane enables; bit 3 is bits [31:24], lane index 0 is the most significant.
  function automatic logic [3:0] lane_mask(input logic word_sel, input logic byte_sel,
                                           input logic [1:0] byte_n);
    if (!word_sel) return 4'b1111;
    if (byte_sel)  return byte_n[0] ? 4'b0011 : 4'b1100;
    return 4'b1000 >> byte_n;
  endfunction

  function automatic logic [31:0] lane_fill(input logic word_sel, input logic byte_sel,
                                            input logic [31:0] data);
    if (!word_sel) return data;
    if (byte_sel)  return {2{data[15:0]}};
    return {4{data[7:0]}};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] base, input logic [31:0] fill,
                                             input logic [3:0] mask);
    logic [31:0] res;
    for (int unsigned j = 0; j < 4; j++)
      res[8*j +: 8] = mask[j] ? fill[8*j +: 8] : base[8*j +: 8];
    return res;
  endfunction

  assign w_req_mask = lane_mask(bus.req_word_sel, bus.req_byte_sel, bus.req_byte_n);
  assign w_req_fill = lane_fill(bus.req_word_sel, bus.req_byte_sel, bus.req_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = (bus.req_word_sel && !BE_EN) ? S_RD : S_WR;
      end
      S_RD:   if (bus.mem_ack) w_state_nxt = S_WR;
      S_WR:   if (bus.mem_ack) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The request is held as a lane mask plus lane-replicated data; that is all
  // the merge needs, so byte_n/byte_sel/word_sel are not kept separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_done      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mask      <= '0;
      r_wdata     <= '0;
    end else begin
      r_mem_req <= (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
      r_mem_we  <= (w_state_nxt == S_WR);
      r_done    <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_mem_addr  <= bus.req_addr;
        r_mask      <= w_req_mask;
        r_wdata     <= w_req_fill;
        r_mem_wdata <= lane_merge('0, w_req_fill, w_req_mask);
      end else if (r_state == S_RD && bus.mem_ack) begin
        r_mem_wdata <= lane_merge(bus.mem_rdata, r_wdata, r_mask);
      end
    end
  end

`ifdef UMIPS_STORE_BE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_mem_be <= '0;
    else if (w_accept)             r_mem_be <= w_req_mask;
    else if (w_state_nxt != S_WR)  r_mem_be <= '0;
  end
  assign bus.mem_be = r_mem_be;
`endif

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.done      = r_done;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_umips_storemerge.sv
// Self-checking bench for umips_storemerge: directed plan steps then random stores
// checked against a byte-rule reference memory. Honours UMIPS_STORE_BE_EN.
module tb_umips_storemerge;
  localparam int unsigned ADDR_W = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  umips_storemerge_if #(.ADDR_W(ADDR_W)) bus();
  umips_storemerge #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [31:0] tb_mem  [32];
  logic [31:0] ref_mem [32];

  int unsigned wait_cfg = 0;
  int unsigned wcnt     = 0;
  int unsigned done_cnt = 0;
  int unsigned stab_err = 0;

  logic              log_we   [$];
  logic [ADDR_W-1:0] log_addr [$];
  logic [31:0]       log_data [$];
  logic [3:0]        log_be   [$];

  logic              pend = 1'b0;
  logic [ADDR_W-1:0] p_addr;
  logic              p_we;
  logic [31:0]       p_wdata;

  // Memory responder: answers mem_req after wait_cfg idle cycles, acks on the negedge.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
      if (pend && bus.mem_req === 1'b1 &&
          (bus.mem_addr !== p_addr || bus.mem_we !== p_we || bus.mem_wdata !== p_wdata))
        stab_err++;
      if (!rst_n || bus.mem_req !== 1'b1) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
        pend = 1'b0;
      end else if (wcnt >= wait_cfg) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = tb_mem[bus.mem_addr[4:0]];
        log_we.push_back(bus.mem_we);
        log_addr.push_back(bus.mem_addr);
        log_data.push_back(bus.mem_wdata);
`ifdef UMIPS_STORE_BE_EN
        log_be.push_back(bus.mem_be);
        if (bus.mem_we)
          for (int j = 0; j < 4; j++)
            if (bus.mem_be[j]) tb_mem[bus.mem_addr[4:0]][8*j +: 8] = bus.mem_wdata[8*j +: 8];
`else
        log_be.push_back(4'hF);
        if (bus.mem_we) tb_mem[bus.mem_addr[4:0]] = bus.mem_wdata;
`endif
        wcnt = 0;
        pend = 1'b0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
        pend    = 1'b1;
        p_addr  = bus.mem_addr;
        p_we    = bus.mem_we;
        p_wdata = bus.mem_wdata;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preset(input int unsigned a, input logic [31:0] v);
    tb_mem[a[4:0]]  = v;
    ref_mem[a[4:0]] = v;
  endtask

  task automatic clear_log();
    log_we.delete(); log_addr.delete(); log_data.delete(); log_be.delete();
  endtask

  task automatic scramble_req();
    bus.req_valid    = 1'b0;
    bus.req_addr     = ADDR_W'($urandom);
    bus.req_byte_n   = 2'($urandom);
    bus.req_byte_sel = 1'($urandom);
    bus.req_word_sel = 1'($urandom);
    bus.req_wdata    = $urandom;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, 32'(bus.req_ready), 32'd1);
    check({pfx, "_done"},  32'(bus.done),      32'd0);
    check({pfx, "_req"},   32'(bus.mem_req),   32'd0);
    check({pfx, "_we"},    32'(bus.mem_we),    32'd0);
    check({pfx, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({pfx, "_wdata"}, bus.mem_wdata,      32'd0);
`ifdef UMIPS_STORE_BE_EN
    check({pfx, "_be"},    32'(bus.mem_be),    32'd0);
`endif
  endtask

  task automatic do_store(input int unsigned addr, input logic [1:0] bn, input logic bs,
                          input logic ws, input logic [31:0] wd, input int unsigned w);
    logic [31:0] old, m, placed, nw, exp_wr;
    logic [3:0]  exp_be;
    int unsigned sh, exp_lat, exp_n, lat, stab0;
    logic        busy_ok;
    old = ref_mem[addr[4:0]];
    if (!ws) begin
      m = 32'hFFFF_FFFF; sh = 0;
    end else if (bs) begin
      sh = bn[0] ? 0 : 16; m = 32'h0000_FFFF << sh;
    end else begin
      sh = 24 - 8 * int'(bn); m = 32'h0000_00FF << sh;
    end
    placed = (wd << sh) & m;
    nw     = (old & ~m) | placed;
    for (int j = 0; j < 4; j++) exp_be[j] = m[8*j];
`ifdef UMIPS_STORE_BE_EN
    exp_wr = placed; exp_n = 1; exp_lat = 2 + w;
`else
    exp_wr = nw; exp_be = 4'hF;
    exp_n   = ws ? 2 : 1;
    exp_lat = ws ? 3 + 2 * w : 2 + w;
`endif
    ref_mem[addr[4:0]] = nw;

    clear_log();
    wait_cfg = w;
    stab0    = stab_err;
    @(negedge clk);
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_addr     = ADDR_W'(addr);
    bus.req_byte_n   = bn;
    bus.req_byte_sel = bs;
    bus.req_word_sel = ws;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    scramble_req();
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("done_latency", lat, exp_lat);
    check("ready_low_busy", 32'(busy_ok), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("access_count", log_we.size(), exp_n);
    if (log_we.size() == exp_n) begin
      if (exp_n == 2) begin
        check("rd_we",   32'(log_we[0]),   32'd0);
        check("rd_addr", 32'(log_addr[0]), addr);
      end
      check("wr_we",   32'(log_we[exp_n-1]),   32'd1);
      check("wr_addr", 32'(log_addr[exp_n-1]), addr);
      check("wr_data", log_data[exp_n-1],      exp_wr);
      check("wr_be",   32'(log_be[exp_n-1]),   32'(exp_be));
    end
    check("mem_word", tb_mem[addr[4:0]], ref_mem[addr[4:0]]);
    check("bus_stable", stab_err - stab0, 32'd0);
  endtask

  initial begin
    int unsigned d0, nwr;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_byte_n = '0;
    bus.req_byte_sel = 1'b0; bus.req_word_sel = 1'b0; bus.req_wdata = '0;
    for (int i = 0; i < 32; i++) preset(i, $urandom);

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_store(32'h10, 2'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
    preset(32'h10, 32'h1122_3344);
    do_store(32'h10, 2'd2, 1'b0, 1'b1, 32'h0000_00AA, 0);
    preset(32'h10, 32'h1122_3344);
    do_store(32'h10, 2'b01, 1'b1, 1'b1, 32'h0000_CAFE, 0);
    preset(32'h10, 32'h1122_3344);
    do_store(32'h10, 2'b10, 1'b1, 1'b1, 32'h0000_CAFE, 0);
    preset(32'h3, 32'h1122_3344);
    do_store(32'h3, 2'd3, 1'b0, 1'b1, 32'h1234_5677, 3);
    do_store(32'h4, 2'd1, 1'b1, 1'b0, 32'hA5A5_0F0F, 3);

    // Reset while the first memory access of a sub-word store is pending.
    preset(5, 32'h5566_7788);
    clear_log();
    wait_cfg = 20;
    d0 = done_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = ADDR_W'(5); bus.req_byte_n = 2'd1;
    bus.req_byte_sel = 1'b0; bus.req_word_sel = 1'b1; bus.req_wdata = 32'h0000_00EE;
    @(posedge clk);
    #1;
    scramble_req();
    repeat (2) @(negedge clk);
    check("pre_abort_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    nwr = 0;
    foreach (log_we[i]) if (log_we[i]) nwr++;
    check("abort_done", done_cnt - d0, 32'd0);
    check("abort_writes", nwr, 32'd0);
    check("abort_mem", tb_mem[5], ref_mem[5]);
    do_store(5, 2'd1, 1'b0, 1'b1, 32'h0000_00EE, 0);

    for (int n = 0; n < 40; n++)
      do_store($urandom_range(0, 31), 2'($urandom), 1'($urandom), 1'($urandom),
               $urandom, $urandom_range(0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/umips_storemerge.md
# umips_storemerge

Store-side lane placer and memory write sequencer for the umips load/store path, the write-direction counterpart of the load byte/halfword extractor. Accepts one store request (word, halfword or byte, big-endian lane numbering), places the store data into the correct lanes of a 32-bit word, and drives a single-port data memory. Sub-word stores become a read-modify-write (RMW) sequence, unless byte-enable support is compiled in.

## Interface
- ADDR_W, 30: word-address width (byte address bits [31:2]).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block idle and accepting; high only in IDLE.
- req_addr  in  ADDR_W  word address of the store.
- req_byte_n  in  2  byte index (byte store) or halfword index in bit 0 (halfword store); index 0 is the most significant lane.
- req_byte_sel  in  1  0 = byte, 1 = halfword (used only when req_word_sel = 1).
- req_word_sel  in  1  0 = full word, 1 = sub-word selected by req_byte_sel.
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- done  out  1  one-cycle pulse when the store has been written.
- mem_req  out  1  memory access request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables, bit 3 = bits [31:24] (only when UMIPS_STORE_BE_EN defined).
- mem_rdata  in  32  read data, valid in the mem_ack cycle of a read.
- mem_ack  in  1  completes the current mem_req in the same cycle.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: req_ready = 1. On req_valid, latch addr, byte_n, byte_sel, word_sel and wdata, then go to WR for a full word or to RD for a sub-word. With UMIPS_STORE_BE_EN defined, sub-words also go to WR.
- RD: mem_req = 1, mem_we = 0, mem_addr = latched address. On mem_ack, capture mem_rdata into the merge register and go to WR.
- WR: mem_req = 1, mem_we = 1. On mem_ack go to DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- Lane placement for a byte at index k: bits [31-8k : 24-8k] = wdata[7:0].
- Lane placement for a halfword at index h = byte_n[0]: bits [31-16h : 16-16h] = wdata[15:0]. byte_n[1] is ignored.
- RMW write data is the read word with only the selected lanes replaced. A full-word store writes wdata unchanged.
- Latched request fields are immune to input changes while busy. mem_ack outside RD/WR is ignored.
- Reset, including mid-operation, aborts the sequence and returns to IDLE. No done is produced and no write is issued for the aborted request.
- Reset values: req_ready = 1; done, mem_req and mem_we = 0; mem_addr, mem_wdata and mem_be = 0.

## Timing
- All outputs are registered except req_ready, which is decoded from the state.
- Full word with zero-wait memory: accept in cycle 0, WR with ack in cycle 1, done in cycle 2. Back-to-back acceptance is possible in cycle 3.
- Sub-word RMW with zero-wait memory: accept in cycle 0, RD+ack in cycle 1, WR+ack in cycle 2, done in cycle 3.
- Each wait cycle on mem_ack adds one cycle in the affected state. mem_addr, mem_we and mem_wdata stay stable while mem_req is high.

## Configuration
- UMIPS_STORE_BE_EN defined:
  - mem_be port exists.
  - Sub-word stores skip RD and write the lane-placed data, with non-selected lanes zero. mem_be marks the selected lanes: byte k gives 4'b1000 >> k; halfword 0 gives 4'b1100; halfword 1 gives 4'b0011.
  - Full-word stores use mem_be = 4'b1111.
  - mem_be is 0 in IDLE and RD.
- UMIPS_STORE_BE_EN undefined: no mem_be port, and every sub-word store performs RMW.

## Test plan
- Full word, addr 0x10, wdata 0xDEADBEEF, mem_ack immediate: one write of 0xDEADBEEF to 0x10, no read, done in cycle 2.
- Byte store, byte_n 2, wdata 0x000000AA, memory holds 0x11223344: read then write 0x1122AA44, done in cycle 3. With BE_EN: single write, mem_be 4'b0010, data 0x0000AA00.
- Halfword store, byte_n 2'b01 then 2'b10, wdata 0x0000CAFE over 0x11223344: writes 0x1122CAFE, then 0xCAFE3344 (bit 1 ignored).
- mem_ack delayed 3 cycles in both RD and WR: request signals stay stable, done arrives 6 cycles later than the zero-wait case, and req_ready stays low throughout.
- Change req_* inputs while busy: the written word reflects only the original latched request.
- Assert rst_n low during RD: all outputs return to reset values at once, no write and no done occur, and the next request completes normally.
